surfboard_mmu: RTL and testbench
================================

SURFBOARD_MMU -- requirements
Module: surfboard_mmu

Interface
REQ-001 The parameter N SHALL default to 2 and give the square matrix dimension, N >= 2.
REQ-002 The parameter W SHALL default to 4 and give the element width of A and B.
REQ-003 The parameter SIGNED SHALL default to 1 and select two's-complement (1) or unsigned (0) operands.
REQ-004 The parameter OW SHALL default to 2*W+$clog2(N) and give the result element width.
REQ-005 The module SHALL have one clock; reset SHALL be asynchronous and active-low.
REQ-006 Port clk, input, 1 bit: the clock.
REQ-007 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-008 Port in_valid, input, 1 bit: the operands are valid.
REQ-009 Port in_ready, output, 1 bit: the block accepts operands.
REQ-010 Port acc_en, input, 1 bit: qualified by the input handshake; accumulate onto the previous C.
REQ-011 Port a, input, [0:N*N-1][W-1:0]: matrix A, row-major, element (i,k) at index i*N+k.
REQ-012 Port b, input, [0:N*N-1][W-1:0]: matrix B, row-major.
REQ-013 Port out_valid, output, 1 bit: c holds a completed result.
REQ-014 Port out_ready, input, 1 bit: the consumer accepts c.
REQ-015 Port c, output, [0:N*N-1][OW-1:0]: matrix C, row-major, registered.
REQ-016 Port busy, output, 1 bit: high in COMPUTE.

Function
REQ-017 The state machine SHALL have exactly three states: IDLE, COMPUTE and DONE.
REQ-018 in_ready SHALL be 1 only in IDLE; an input transfer SHALL occur on a clk edge where in_valid and in_ready are both 1.
REQ-019 On an input transfer the block SHALL capture a, b and acc_en, set the loop indices i, j, k to 0, and enter COMPUTE.
REQ-020 On an input transfer, each C element SHALL be cleared to 0 when acc_en=0 and SHALL keep its previous value when acc_en=1.
REQ-021 In COMPUTE, exactly one MAC SHALL execute per cycle: C[i][j] += ext(A[i][k]) * ext(B[k][j]).
REQ-022 In REQ-021, ext() SHALL sign-extend to OW bits when SIGNED=1 and zero-extend when SIGNED=0.
REQ-023 The MAC sum SHALL wrap modulo 2^OW.
REQ-024 The indices SHALL advance k fastest, then j, then i.
REQ-025 COMPUTE SHALL last exactly N^3 cycles and then enter DONE.
REQ-026 With the transfer edge numbered cycle 0, out_valid SHALL be 1 from cycle N^3+1.
REQ-027 In DONE, out_valid=1 and c SHALL be stable until a clk edge with out_ready=1; that edge SHALL enter IDLE.
REQ-028 There SHALL be no bypass: in_ready SHALL rise the cycle after the output handshake, so back-to-back throughput is one matrix per N^3+2 cycles.
REQ-029 In IDLE, c SHALL hold the last result for a later acc_en transfer.
REQ-030 Input values during COMPUTE or DONE SHALL be ignored.
REQ-031 out_ready SHALL be ignored outside DONE.

Reset
REQ-032 rst_n=0 SHALL force IDLE immediately, from any state including mid-COMPUTE, aborting the operation.
REQ-033 Under reset, c, the captured operands, acc_en and the indices SHALL be cleared to 0.
REQ-034 Reset values SHALL be: in_ready=1 (IDLE), out_valid=0, busy=0.
REQ-035 An acc_en transfer after reset SHALL accumulate onto zero.

Structure
REQ-036 Package surfboard_pkg SHALL hold the state enum (IDLE, COMPUTE, DONE).
REQ-037 surfboard_pkg SHALL hold the row-major index helper function idx(row, col, n).
REQ-038 One sub-module, surfboard_mac, SHALL hold the W x W -> OW extend-multiply-add, parameterised by W, OW and SIGNED.
REQ-039 The index counters and the C register array SHALL reside in surfboard_mmu.

Verification
REQ-040 Unsigned, N=2, W=4, SIGNED=0: A=[[1,2],[3,4]], B=[[5,6],[7,8]], acc_en=0 -> c=[[19,22],[43,50]], out_valid at cycle 9, busy high for cycles 1..8.
REQ-041 Signed, SIGNED=1: A=[[-8,0],[0,0]], B=[[-1,0],[0,0]] -> c[0]=+8, rest 0; with SIGNED=0 the same bits (8*15) -> c[0]=120.
REQ-042 Accumulate: after REQ-040, hold out_ready=0 for 5 cycles (c stable, in_ready=0), then release; next transfer A=B=identity, acc_en=1 -> c=[[20,22],[43,51]].
REQ-043 Backpressure/throughput: in_valid held 1 with out_ready=1 over 3 operations -> in_ready pulses every 10 cycles, and inputs changed during COMPUTE do not alter results.
REQ-044 Reset abort: assert rst_n=0 at COMPUTE cycle 4 -> outputs at reset values immediately; a new unsigned identity*identity transfer -> c=[[1,0],[0,1]].
REQ-045 Wrap and N=3: with N=3, W=4, SIGNED=0, OW=4, A=B=all 15 -> every c=675 mod 16=3, out_valid at cycle 28.

Source files
------------

// File: rtl/surfboard_pkg.sv
// Shared types and helpers for the surfboard matrix-multiply unit.
package surfboard_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } state_t;

    function automatic int idx(input int row, input int col, input int n);
        return row * n + col;
    endfunction

endpackage

// File: rtl/surfboard_mac.sv
// Single multiply-accumulate lane: extends both operands to OW bits, multiplies,
// adds the accumulator, all modulo 2^OW.
module surfboard_mac #(
    parameter int W      = 4,
    parameter int OW     = 9,
    parameter int SIGNED = 1
) (
    input  logic [W-1:0]  a_i,
    input  logic [W-1:0]  b_i,
    input  logic [OW-1:0] acc_i,
    output logic [OW-1:0] sum_o
);

    logic [OW-1:0] a_ext_s;
    logic [OW-1:0] b_ext_s;
    logic [OW-1:0] prod_s;

    generate
        if (SIGNED != 0) begin : g_sext
            assign a_ext_s = OW'($signed(a_i));
            assign b_ext_s = OW'($signed(b_i));
        end else begin : g_zext
            assign a_ext_s = OW'(a_i);
            assign b_ext_s = OW'(b_i);
        end
    endgenerate

    // Only the low OW bits of the product matter, so signedness is irrelevant here.
    assign prod_s = a_ext_s * b_ext_s;
    assign sum_o  = acc_i + prod_s;

endmodule

// File: rtl/surfboard_mmu.sv
// Sequential N x N matrix multiply (optionally accumulating onto the previous C),
// one MAC per cycle, with valid/ready handshakes on both sides.
module surfboard_mmu
    import surfboard_pkg::*;
#(
    parameter int N      = 2,
    parameter int W      = 4,
    parameter int SIGNED = 1,
    parameter int OW     = 2*W + $clog2(N)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     acc_en,
    input  logic [0:N*N-1][W-1:0]    a,
    input  logic [0:N*N-1][W-1:0]    b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [0:N*N-1][OW-1:0]   c,
    output logic                     busy
);

    localparam int             IW   = $clog2(N);
    localparam int             CW   = $clog2(N*N);
    localparam logic [IW-1:0]  LAST = IW'(N-1);

    state_t                   state_q, state_d;
    logic [IW-1:0]            i_q, i_d, j_q, j_d, k_q, k_d;
    logic [0:N*N-1][W-1:0]    a_q, a_d, b_q, b_d;
    logic                     acc_q, acc_d;
    logic [0:N*N-1][OW-1:0]   c_q, c_d;
    logic                     in_ready_q, in_ready_d;
    logic                     out_valid_q, out_valid_d;
    logic                     busy_q, busy_d;

    logic [CW-1:0]            c_sel_s, a_sel_s, b_sel_s;
    logic [OW-1:0]            addend_s, sum_s;

    assign c_sel_s = CW'(idx(int'(i_q), int'(j_q), N));
    assign a_sel_s = CW'(idx(int'(i_q), int'(k_q), N));
    assign b_sel_s = CW'(idx(int'(k_q), int'(j_q), N));

    // A fresh (non-accumulating) product starts each element from zero on its first term.
    assign addend_s = ((k_q == {IW{1'b0}}) && !acc_q) ? {OW{1'b0}} : c_q[c_sel_s];

    surfboard_mac #(
        .W      (W),
        .OW     (OW),
        .SIGNED (SIGNED)
    ) u_mac (
        .a_i   (a_q[a_sel_s]),
        .b_i   (b_q[b_sel_s]),
        .acc_i (addend_s),
        .sum_o (sum_s)
    );

    // Next-state, index walk, operand capture and C update.
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        c_d     = c_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    acc_d   = acc_en;
                    i_d     = {IW{1'b0}};
                    j_d     = {IW{1'b0}};
                    k_d     = {IW{1'b0}};
                    state_d = COMPUTE;
                    if (!acc_en) begin
                        c_d = {(N*N*OW){1'b0}};
                    end else begin
                        c_d = c_q;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            COMPUTE: begin
                c_d[c_sel_s] = sum_s;
                if (k_q == LAST) begin
                    k_d = {IW{1'b0}};
                    if (j_q == LAST) begin
                        j_d = {IW{1'b0}};
                        if (i_q == LAST) begin
                            i_d     = {IW{1'b0}};
                            state_d = DONE;
                        end else begin
                            i_d = i_q + IW'(1);
                        end
                    end else begin
                        j_d = j_q + IW'(1);
                    end
                end else begin
                    k_d = k_q + IW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d == COMPUTE);
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            i_q         <= {IW{1'b0}};
            j_q         <= {IW{1'b0}};
            k_q         <= {IW{1'b0}};
            a_q         <= {(N*N*W){1'b0}};
            b_q         <= {(N*N*W){1'b0}};
            acc_q       <= 1'b0;
            c_q         <= {(N*N*OW){1'b0}};
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            j_q         <= j_d;
            k_q         <= k_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            c_q         <= c_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign c         = c_q;

endmodule

// File: tb/tb_surfboard_mmu.sv
// Bench for surfboard_mmu: unsigned/signed N=2 instances driven in lockstep plus
// an N=3 narrow-result instance, checked against a matrix-arithmetic reference.
module tb_surfboard_mmu;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic             in_valid, acc_en, out_ready;
    logic [0:3][3:0]  a, b;
    logic             ir0, ov0, bz0, ir1, ov1, bz1;
    logic [0:3][8:0]  c0, c1;
    logic             v3, or3, ir3, ov3, bz3, acc3;
    logic [0:8][3:0]  a3, b3, c3;

    int tests  = 0;
    int failed = 0;

    typedef logic [0:3][31:0] mat4_t;

    typedef struct {
        logic [0:3][3:0] a;
        logic [0:3][3:0] b;
        logic            acc;
        int              hold;
        mat4_t           exp_u;
        mat4_t           exp_s;
    } vec_t;

    vec_t  tbl [3];
    mat4_t prev_u, prev_s;

    surfboard_mmu #(.N(2), .W(4), .SIGNED(0)) u_uns (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir0), .acc_en(acc_en),
        .a(a), .b(b), .out_valid(ov0), .out_ready(out_ready), .c(c0), .busy(bz0));

    surfboard_mmu #(.N(2), .W(4), .SIGNED(1)) u_sgn (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1), .acc_en(acc_en),
        .a(a), .b(b), .out_valid(ov1), .out_ready(out_ready), .c(c1), .busy(bz1));

    surfboard_mmu #(.N(3), .W(4), .SIGNED(0), .OW(4)) u_n3 (
        .clk(clk), .rst_n(rst_n), .in_valid(v3), .in_ready(ir3), .acc_en(acc3),
        .a(a3), .b(b3), .out_valid(ov3), .out_ready(or3), .c(c3), .busy(bz3));

    function automatic int ext4(input logic [3:0] v, input bit sgn);
        if (sgn && v[3]) return int'({28'd0, v}) - 16;
        else             return int'({28'd0, v});
    endfunction

    // C = (acc ? prev : 0) + A*B, reduced modulo 2^9.
    function automatic mat4_t ref_mmu(input logic [0:3][3:0] av, input logic [0:3][3:0] bv,
                                      input logic acc, input bit sgn, input mat4_t prev);
        mat4_t r;
        int    s;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                s = acc ? int'(prev[i*2+j]) : 0;
                for (int k = 0; k < 2; k++) s += ext4(av[i*2+k], sgn) * ext4(bv[k*2+j], sgn);
                r[i*2+j] = 32'(s & 511);
            end
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_c(input string nm, input logic [0:3][8:0] act, input mat4_t exp);
        for (int e = 0; e < 4; e++) chk(nm, 32'(act[e]), exp[e]);
    endtask

    // One full transaction on the N=2 pair; returns one cycle after the output handshake.
    task automatic do_op(input logic [0:3][3:0] av, input logic [0:3][3:0] bv,
                         input logic acc, input int hold, input bit scramble);
        int              lat;
        logic [0:3][8:0] snap;
        chk("in_ready_pre", 32'(ir0), 32'd1);
        a = av; b = bv; acc_en = acc; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("busy_compute", 32'(bz0), 32'd1);
        chk("in_ready_busy", 32'(ir0), 32'd0);
        lat = 0;
        while (!ov0 && lat < 100) begin
            if (scramble) begin
                a = 16'($urandom); b = 16'($urandom);
                acc_en = 1'($urandom); in_valid = 1'($urandom); out_ready = 1'($urandom);
            end
            @(posedge clk); #1;
            lat++;
        end
        out_ready = 1'b0;
        in_valid  = 1'b1;
        chk("latency", 32'(lat), 32'd8);
        chk("busy_done", 32'(bz0), 32'd0);
        snap = c0;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(ov0), 32'd1);
            chk("hold_in_ready", 32'(ir0), 32'd0);
            chk("hold_stable", 32'(c0 == snap), 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("release_idle", 32'(ir0), 32'd1);
        chk("release_valid", 32'(ov0), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int              pulses, last_e, done_n, issued, lat;
        mat4_t           exp_u, exp_s;
        mat4_t           exp_q [3];
        logic [0:3][3:0] ta [3];
        logic [0:3][3:0] tb [3];
        logic [0:3][3:0] ra, rb;
        logic            racc;
        mat4_t           ident_c;

        tbl[0] = '{a: {4'd1, 4'd2, 4'd3, 4'd4}, b: {4'd5, 4'd6, 4'd7, 4'd8}, acc: 1'b0, hold: 5,
                   exp_u: {32'd19, 32'd22, 32'd43, 32'd50}, exp_s: {32'd19, 32'd502, 32'd43, 32'd498}};
        tbl[1] = '{a: {4'd1, 4'd0, 4'd0, 4'd1}, b: {4'd1, 4'd0, 4'd0, 4'd1}, acc: 1'b1, hold: 0,
                   exp_u: {32'd20, 32'd22, 32'd43, 32'd51}, exp_s: {32'd20, 32'd502, 32'd43, 32'd499}};
        tbl[2] = '{a: {4'd8, 4'd0, 4'd0, 4'd0}, b: {4'd15, 4'd0, 4'd0, 4'd0}, acc: 1'b0, hold: 1,
                   exp_u: {32'd120, 32'd0, 32'd0, 32'd0}, exp_s: {32'd8, 32'd0, 32'd0, 32'd0}};
        ident_c = {32'd1, 32'd0, 32'd0, 32'd1};

        rst_n = 1'b0; in_valid = 1'b0; acc_en = 1'b0; out_ready = 1'b0;
        a = 16'd0; b = 16'd0;
        v3 = 1'b0; or3 = 1'b0; acc3 = 1'b0; a3 = 36'd0; b3 = 36'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(ir0), 32'd1);
        chk("rst_out_valid", 32'(ov0), 32'd0);
        chk("rst_busy", 32'(bz0), 32'd0);
        chk("rst_c_zero", 32'(c0 == 36'd0), 32'd1);
        chk("rst_n3_in_ready", 32'(ir3), 32'd1);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors: basic product, accumulate after a stall, sign handling.
        for (int t = 0; t < 3; t++) begin
            do_op(tbl[t].a, tbl[t].b, tbl[t].acc, tbl[t].hold, 1'b0);
            chk_c("tbl_unsigned_c", c0, tbl[t].exp_u);
            chk_c("tbl_signed_c", c1, tbl[t].exp_s);
            prev_u = tbl[t].exp_u;
            prev_s = tbl[t].exp_s;
        end

        // Random operands and accumulate flags, with inputs churning during COMPUTE.
        for (int n = 0; n < 6; n++) begin
            ra = 16'($urandom); rb = 16'($urandom); racc = 1'($urandom);
            exp_u = ref_mmu(ra, rb, racc, 1'b0, prev_u);
            exp_s = ref_mmu(ra, rb, racc, 1'b1, prev_s);
            do_op(ra, rb, racc, int'($urandom_range(0, 2)), 1'b1);
            chk_c("rand_unsigned_c", c0, exp_u);
            chk_c("rand_signed_c", c1, exp_s);
            prev_u = exp_u;
            prev_s = exp_s;
        end

        // Back-to-back throughput with in_valid and out_ready held high.
        for (int n = 0; n < 3; n++) begin
            ta[n] = 16'($urandom); tb[n] = 16'($urandom);
            exp_q[n] = ref_mmu(ta[n], tb[n], 1'b0, 1'b0, prev_u);
        end
        pulses = 0; last_e = 0; done_n = 0; issued = 0;
        acc_en = 1'b0; out_ready = 1'b1;
        for (int e = 0; e < 80 && pulses < 4; e++) begin
            if (e > 0) begin
                @(posedge clk); #1;
            end
            if (ov0) begin
                if (done_n < 3) chk_c("tput_c", c0, exp_q[done_n]);
                done_n++;
            end
            if (ir0) begin
                if (pulses > 0) chk("tput_gap", 32'(e - last_e), 32'd10);
                last_e = e;
                pulses++;
                if (issued < 3) begin
                    a = ta[issued]; b = tb[issued]; in_valid = 1'b1;
                    issued++;
                end else begin
                    in_valid = 1'b0;
                end
            end else begin
                a = 16'($urandom); b = 16'($urandom);
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        chk("tput_pulses", 32'(pulses), 32'd4);
        chk("tput_results", 32'(done_n), 32'd3);

        // Reset in the middle of COMPUTE, then accumulate onto the cleared C.
        a = 16'($urandom); b = 16'($urandom); acc_en = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_in_ready", 32'(ir0), 32'd1);
        chk("abort_out_valid", 32'(ov0), 32'd0);
        chk("abort_busy", 32'(bz0), 32'd0);
        chk("abort_c_zero", 32'(c0 == 36'd0), 32'd1);
        chk("abort_signed_busy", 32'(bz1), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        do_op({4'd1, 4'd0, 4'd0, 4'd1}, {4'd1, 4'd0, 4'd0, 4'd1}, 1'b1, 0, 1'b0);
        chk_c("abort_ident_u", c0, ident_c);
        chk_c("abort_ident_s", c1, ident_c);

        // N=3 with a 4-bit result: 3*15*15 wraps modulo 16.
        for (int e = 0; e < 9; e++) begin
            a3[e] = 4'd15;
            b3[e] = 4'd15;
        end
        v3 = 1'b1;
        @(posedge clk); #1;
        v3 = 1'b0;
        lat = 0;
        while (!ov3 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("n3_latency", 32'(lat), 32'd27);
        for (int e = 0; e < 9; e++) chk("n3_wrap_c", 32'(c3[e]), 32'((3 * 15 * 15) % 16));
        or3 = 1'b1;
        @(posedge clk); #1;
        or3 = 1'b0;
        chk("n3_release_idle", 32'(ir3), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
